hp0arb: RTL and testbench



---
 rtl/hp0arb_pkg.sv | 26 ++
 rtl/hp0cnt.sv | 38 +++
 rtl/hp0arb.sv | 196 +++++++++++++++++++
 tb/tb_hp0arb.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hp0arb_pkg.sv
// hp0arb shared definitions: HP0 AXI constants, FSM state type,
// registered AR request bundle and the round-robin pick helper.
package hp0arb_pkg;

    localparam int         HP0_ID_W   = 12;
    localparam logic [2:0] ARSIZE_64  = 3'd3;
    localparam logic [1:0] BURST_INCR = 2'd1;
    localparam int         CNT_W      = 4;

    typedef enum logic {
        IDLE = 1'b0,
        ADDR = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic        id;
    } ar_req_t;

    // On a tie the master that was not served last wins.
    function automatic logic rr_pick(input logic last);
        return ~last;
    endfunction

endpackage

// File: rtl/hp0cnt.sv
// hp0cnt: 4-bit outstanding-burst counter, up on inc_i, down on dec_i,
// saturating at 0. Ports: clk, reset, inc_i, dec_i, full_o (count==MAXOUT).
module hp0cnt
    import hp0arb_pkg::*;
#(
    parameter int MAXOUT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && cnt_q != '0) begin
            // Stale rlast after a reset must not wrap the count.
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full_o = (cnt_q == CNT_W'(MAXOUT));

endmodule

// File: rtl/hp0arb.sv
// hp0arb: shares the HP0 AXI3 read port between master 0 (framebuffer
// DMA, with urgency override) and master 1 (cursor fetch). Round-robin
// AR arbitration, per-master outstanding limit MAXOUT, R routed by rid[0].
// Ports: clk, reset (sync, active-high), m0_/m1_ AR+R channels,
// m0_urgent, hp0_ AR+R channels. Define HP0ARB_STATS_EN to add
// stat0/stat1 (R beats per master) and statstall (AR stall cycles).
module hp0arb
    import hp0arb_pkg::*;
#(
    parameter int MAXOUT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         m0_araddr,
    input  logic [3:0]          m0_arlen,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    output logic [63:0]         m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rlast,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    input  logic                m0_urgent,
    input  logic [31:0]         m1_araddr,
    input  logic [3:0]          m1_arlen,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    output logic [63:0]         m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rlast,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    output logic [31:0]         hp0_araddr,
    output logic [3:0]          hp0_arlen,
    output logic [2:0]          hp0_arsize,
    output logic [1:0]          hp0_arburst,
    output logic [HP0_ID_W-1:0] hp0_arid,
    output logic                hp0_arvalid,
    input  logic                hp0_arready,
    input  logic [63:0]         hp0_rdata,
    input  logic [1:0]          hp0_rresp,
    input  logic                hp0_rlast,
    input  logic [HP0_ID_W-1:0] hp0_rid,
    input  logic                hp0_rvalid,
    output logic                hp0_rready
`ifdef HP0ARB_STATS_EN
    ,
    output logic [31:0]         stat0,
    output logic [31:0]         stat1,
    output logic [31:0]         statstall
`endif
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    ar_req_t    req_q, req_d;

    logic full0, full1;
    logic elig0, elig1;
    logic gnt_vld, gnt1;
    logic inc0, inc1;
    logic dec0, dec1;
    logic sel;
    logic rbeat;
    logic rid_unused;

    // Reset masks eligibility so no request is accepted while in reset.
    assign elig0 = m0_arvalid && !full0 && !reset;
    assign elig1 = m1_arvalid && !full1 && !reset;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        req_d       = req_q;
        gnt_vld     = 1'b0;
        gnt1        = 1'b0;
        m0_arready  = 1'b0;
        m1_arready  = 1'b0;
        hp0_arvalid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (m0_urgent && elig0) begin
                    gnt_vld = 1'b1;
                    gnt1    = 1'b0;
                end else if (elig0 && elig1) begin
                    gnt_vld = 1'b1;
                    gnt1    = rr_pick(last_q);
                end else if (elig0) begin
                    gnt_vld = 1'b1;
                    gnt1    = 1'b0;
                end else if (elig1) begin
                    gnt_vld = 1'b1;
                    gnt1    = 1'b1;
                end
                m0_arready = gnt_vld && !gnt1;
                m1_arready = gnt_vld && gnt1;
                if (gnt_vld) begin
                    req_d.addr = gnt1 ? m1_araddr : m0_araddr;
                    req_d.len  = gnt1 ? m1_arlen : m0_arlen;
                    req_d.id   = gnt1;
                    last_d     = gnt1;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                hp0_arvalid = 1'b1;
                if (hp0_arready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            req_q   <= req_d;
        end
    end

    assign hp0_araddr  = req_q.addr;
    assign hp0_arlen   = req_q.len;
    assign hp0_arid    = {{(HP0_ID_W-1){1'b0}}, req_q.id};
    assign hp0_arsize  = ARSIZE_64;
    assign hp0_arburst = BURST_INCR;

    // R path: purely combinational steer on rid[0].
    assign sel        = hp0_rid[0];
    assign rid_unused = ^hp0_rid[HP0_ID_W-1:1];
    assign hp0_rready = sel ? m1_rready : m0_rready;
    assign m0_rvalid  = hp0_rvalid && !sel;
    assign m1_rvalid  = hp0_rvalid && sel;
    assign m0_rdata   = hp0_rdata;
    assign m1_rdata   = hp0_rdata;
    assign m0_rresp   = hp0_rresp;
    assign m1_rresp   = hp0_rresp;
    assign m0_rlast   = hp0_rlast;
    assign m1_rlast   = hp0_rlast;

    assign rbeat = hp0_rvalid && hp0_rready;
    assign inc0  = m0_arvalid && m0_arready;
    assign inc1  = m1_arvalid && m1_arready;
    assign dec0  = rbeat && hp0_rlast && !sel;
    assign dec1  = rbeat && hp0_rlast && sel;

    hp0cnt #(.MAXOUT(MAXOUT)) u_cnt0 (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (inc0),
        .dec_i  (dec0),
        .full_o (full0)
    );

    hp0cnt #(.MAXOUT(MAXOUT)) u_cnt1 (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (inc1),
        .dec_i  (dec1),
        .full_o (full1)
    );

`ifdef HP0ARB_STATS_EN
    logic [31:0] stat0_q, stat1_q, stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat0_q <= '0;
            stat1_q <= '0;
            stall_q <= '0;
        end else begin
            if (rbeat && !sel) begin
                stat0_q <= stat0_q + 32'd1;
            end
            if (rbeat && sel) begin
                stat1_q <= stat1_q + 32'd1;
            end
            if (hp0_arvalid && !hp0_arready) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign stat0     = stat0_q;
    assign stat1     = stat1_q;
    assign statstall = stall_q;
`endif

endmodule

// File: tb/tb_hp0arb.sv
// Directed bench for hp0arb (MAXOUT=4): arbitration order, urgency,
// outstanding limits, AR stall stability, R routing and reset in ADDR.
module tb_hp0arb;
    import hp0arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_araddr, m1_araddr;
    logic [3:0]  m0_arlen, m1_arlen;
    logic        m0_arvalid, m1_arvalid;
    logic        m0_arready, m1_arready;
    logic [63:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp;
    logic        m0_rlast, m1_rlast;
    logic        m0_rvalid, m1_rvalid;
    logic        m0_rready, m1_rready;
    logic        m0_urgent;
    logic [31:0] hp0_araddr;
    logic [3:0]  hp0_arlen;
    logic [2:0]  hp0_arsize;
    logic [1:0]  hp0_arburst;
    logic [11:0] hp0_arid;
    logic        hp0_arvalid;
    logic        hp0_arready;
    logic [63:0] hp0_rdata;
    logic [1:0]  hp0_rresp;
    logic        hp0_rlast;
    logic [11:0] hp0_rid;
    logic        hp0_rvalid;
    logic        hp0_rready;

    int checks   = 0;
    int failures = 0;
    int beat_n   = 0;
    logic [31:0] a0 = 32'h1000_0000;
    logic [31:0] a1 = 32'h2000_0000;
    logic [3:0]  l0 = 4'd3;
    logic [3:0]  l1 = 4'd0;
    ar_req_t     sb[$];

    always #5 clk = ~clk;

    hp0arb #(.MAXOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .m0_araddr   (m0_araddr),
        .m0_arlen    (m0_arlen),
        .m0_arvalid  (m0_arvalid),
        .m0_arready  (m0_arready),
        .m0_rdata    (m0_rdata),
        .m0_rresp    (m0_rresp),
        .m0_rlast    (m0_rlast),
        .m0_rvalid   (m0_rvalid),
        .m0_rready   (m0_rready),
        .m0_urgent   (m0_urgent),
        .m1_araddr   (m1_araddr),
        .m1_arlen    (m1_arlen),
        .m1_arvalid  (m1_arvalid),
        .m1_arready  (m1_arready),
        .m1_rdata    (m1_rdata),
        .m1_rresp    (m1_rresp),
        .m1_rlast    (m1_rlast),
        .m1_rvalid   (m1_rvalid),
        .m1_rready   (m1_rready),
        .hp0_araddr  (hp0_araddr),
        .hp0_arlen   (hp0_arlen),
        .hp0_arsize  (hp0_arsize),
        .hp0_arburst (hp0_arburst),
        .hp0_arid    (hp0_arid),
        .hp0_arvalid (hp0_arvalid),
        .hp0_arready (hp0_arready),
        .hp0_rdata   (hp0_rdata),
        .hp0_rresp   (hp0_rresp),
        .hp0_rlast   (hp0_rlast),
        .hp0_rid     (hp0_rid),
        .hp0_rvalid  (hp0_rvalid),
        .hp0_rready  (hp0_rready)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    // Return one rlast beat to master m with both masters ready.
    task automatic ret(input int m);
        logic [63:0] d;
        d = {32'hBEEF_0000, 32'(beat_n)};
        beat_n++;
        hp0_rvalid = 1'b1;
        hp0_rlast  = 1'b1;
        hp0_rid    = {11'h5A3, m[0]};
        hp0_rdata  = d;
        hp0_rresp  = 2'b10;
        m0_rready  = 1'b1;
        m1_rready  = 1'b1;
        #1;
        chk("r_vld0", m0_rvalid, m == 0);
        chk("r_vld1", m1_rvalid, m == 1);
        chk("r_rdy", hp0_rready, 1'b1);
        chk("r_data", (m == 0) ? m0_rdata : m1_rdata, d);
        chk("r_last", (m == 0) ? m0_rlast : m1_rlast, 1'b1);
        clk1();
        hp0_rvalid = 1'b0;
        hp0_rlast  = 1'b0;
    endtask

    // One IDLE cycle expecting grant g (-1: none), then ADDR with
    // 'stall' cycles of hp0_arready low. rb>=0 returns an rlast to
    // master rb during the IDLE cycle.
    task automatic step(input int g, input int stall, input int rb);
        ar_req_t e;
        m0_araddr = a0;
        m0_arlen  = l0;
        m1_araddr = a1;
        m1_arlen  = l1;
        if (rb >= 0) begin
            hp0_rvalid = 1'b1;
            hp0_rlast  = 1'b1;
            hp0_rid    = {11'h000, rb[0]};
            m0_rready  = 1'b1;
            m1_rready  = 1'b1;
        end
        #1;
        chk("idle_arvalid", hp0_arvalid, 1'b0);
        chk("arready0", m0_arready, g == 0);
        chk("arready1", m1_arready, g == 1);
        if (g >= 0) begin
            e.addr = (g == 1) ? a1 : a0;
            e.len  = (g == 1) ? l1 : l0;
            e.id   = g[0];
            sb.push_back(e);
        end
        hp0_arready = (stall == 0);
        clk1();
        hp0_rvalid = 1'b0;
        hp0_rlast  = 1'b0;
        if (g < 0) return;
        if (g == 1) begin
            a1 = a1 + 32'h40;
            l1 = l1 + 4'd1;
        end else begin
            a0 = a0 + 32'h100;
            l0 = l0 + 4'd5;
        end
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        for (int i = 0; i < stall; i++) begin
            chk("stall_vld", hp0_arvalid, 1'b1);
            chk("stall_addr", hp0_araddr, e.addr);
            clk1();
        end
        hp0_arready = 1'b1;
        chk("ar_vld", hp0_arvalid, 1'b1);
        chk("ar_id", hp0_arid, {11'h000, e.id});
        chk("ar_addr", hp0_araddr, e.addr);
        chk("ar_len", hp0_arlen, e.len);
        chk("ar_size", hp0_arsize, 3'd3);
        chk("ar_burst", hp0_arburst, 2'd1);
        chk("addr_nogrant0", m0_arready, 1'b0);
        chk("addr_nogrant1", m1_arready, 1'b0);
        clk1();
    endtask

    initial begin
        ar_req_t e;
        reset       = 1'b1;
        m0_araddr   = '0;
        m0_arlen    = '0;
        m0_arvalid  = 1'b1;
        m1_araddr   = '0;
        m1_arlen    = '0;
        m1_arvalid  = 1'b0;
        m0_urgent   = 1'b0;
        m0_rready   = 1'b0;
        m1_rready   = 1'b0;
        hp0_arready = 1'b1;
        hp0_rdata   = '0;
        hp0_rresp   = '0;
        hp0_rlast   = 1'b0;
        hp0_rid     = '0;
        hp0_rvalid  = 1'b0;
        repeat (3) clk1();
        chk("rst_arvalid", hp0_arvalid, 1'b0);
        chk("rst_arready0", m0_arready, 1'b0);
        chk("rst_araddr", hp0_araddr, 32'h0);
        chk("rst_arlen", hp0_arlen, 4'h0);
        chk("rst_arid", hp0_arid, 12'h0);
        reset      = 1'b0;
        m0_arvalid = 1'b0;

        // Round robin, master 0 first.
        step(-1, 0, -1);
        m0_arvalid = 1'b1;
        m1_arvalid = 1'b1;
        step(0, 0, -1);
        step(1, 0, -1);
        step(0, 0, -1);
        step(1, 0, -1);
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
        ret(0);
        ret(0);
        ret(1);
        ret(1);

        // Urgency overrides round robin.
        m0_urgent  = 1'b1;
        m0_arvalid = 1'b1;
        m1_arvalid = 1'b1;
        repeat (4) step(0, 0, -1);
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
        ret(0);
        m0_arvalid = 1'b1;
        m1_arvalid = 1'b1;
        step(0, 0, -1);
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
        ret(0);
        m0_urgent  = 1'b0;
        m0_arvalid = 1'b1;
        m1_arvalid = 1'b1;
        step(1, 0, -1);

        // Master 0 at its limit does not block master 1.
        step(0, 0, -1);
        step(1, 0, -1);
        step(1, 0, -1);
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
        ret(0);
        m0_arvalid = 1'b1;
        m1_arvalid = 1'b1;
        step(0, 0, -1);

        // Drain, then AR stall of 5 cycles.
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
        repeat (4) ret(0);
        repeat (3) ret(1);
        m1_arvalid = 1'b1;
        step(1, 5, -1);
        m1_arvalid = 1'b0;

        // R routing with master 1 not ready.
        hp0_rvalid = 1'b1;
        hp0_rlast  = 1'b0;
        hp0_rid    = 12'hFF1;
        m0_rready  = 1'b1;
        m1_rready  = 1'b0;
        #1;
        chk("rsel_rready", hp0_rready, 1'b0);
        chk("rsel_vld0", m0_rvalid, 1'b0);
        chk("rsel_vld1", m1_rvalid, 1'b1);
        clk1();
        hp0_rvalid = 1'b0;

        // Simultaneous inc and dec on counter 1: stays at 1.
        m1_arvalid = 1'b1;
        step(1, 0, 1);
        step(1, 0, -1);
        step(1, 0, -1);
        step(1, 0, -1);
        step(-1, 0, -1);
        m1_arvalid = 1'b0;
        repeat (4) ret(1);

        // Reset in ADDR with out0=3.
        m0_arvalid = 1'b1;
        repeat (3) step(0, 0, -1);
        m0_araddr   = a0;
        m0_arlen    = l0;
        #1;
        chk("pre_rst_gnt", m0_arready, 1'b1);
        hp0_arready = 1'b0;
        e.addr = a0;
        e.len  = l0;
        e.id   = 1'b0;
        sb.push_back(e);
        clk1();
        e = sb.pop_front();
        chk("pre_rst_vld", hp0_arvalid, 1'b1);
        chk("pre_rst_addr", hp0_araddr, e.addr);
        reset = 1'b1;
        clk1();
        chk("rst_addr_vld", hp0_arvalid, 1'b0);
        chk("rst_addr_araddr", hp0_araddr, 32'h0);
        chk("rst_addr_arready", m0_arready, 1'b0);
        reset       = 1'b0;
        m0_arvalid  = 1'b0;
        hp0_arready = 1'b1;
        ret(0);
        m0_arvalid = 1'b1;
        repeat (4) step(0, 0, -1);
        step(-1, 0, -1);
        m0_arvalid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
